// File: rtl/imm_encoder.sv
// Two-stage RISC-V immediate encoder: inserts a decoded immediate into an instruction template.
// Optional saturating error counter enabled by defining IMMENC_ERRCNT_EN.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_immsrc,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_U = 3'b001;
    localparam logic [2:0] FMT_S = 3'b010;
    localparam logic [2:0] FMT_B = 3'b011;
    localparam logic [2:0] FMT_J = 3'b100;

    logic        advance;
    logic        range_err;
    logic        s1_valid;
    logic [2:0]  s1_immsrc;
    logic [31:0] s1_imm;
    logic [31:0] s1_base;
    logic        s1_err;
    logic [31:0] merged;

    // Both stages move together, so a stalled output freezes the whole pipe.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        range_err = 1'b0;
        case (in_immsrc)
            FMT_I, FMT_S, FMT_B: range_err = !((&in_imm[31:11]) || !(|in_imm[31:11]));
            FMT_U:               range_err = |in_imm[11:0];
            FMT_J:               range_err = !((&in_imm[31:19]) || !(|in_imm[31:19]));
            default:             range_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_immsrc <= '0;
            s1_imm    <= '0;
            s1_base   <= '0;
            s1_err    <= 1'b0;
        end else begin
            if (advance) begin
                s1_immsrc <= in_immsrc;
                s1_imm    <= in_imm;
                s1_base   <= in_base;
                s1_err    <= range_err;
            end
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (advance) begin
                s1_valid <= in_valid;
            end
        end
    end

    // Out-of-range values still get their truncated low bits inserted.
    always_comb begin
        merged = s1_base;
        case (s1_immsrc)
            FMT_I: merged = {s1_imm[11:0], s1_base[19:0]};
            FMT_U: merged = {s1_imm[31:12], s1_base[11:0]};
            FMT_S: merged = {s1_imm[11:5], s1_base[24:12], s1_imm[4:0], s1_base[6:0]};
            FMT_B: merged = {s1_imm[11], s1_imm[9:4], s1_base[24:12], s1_imm[3:0],
                             s1_imm[10], s1_base[6:0]};
            FMT_J: merged = {s1_imm[19], s1_imm[9:0], s1_imm[10], s1_imm[18:11],
                             s1_base[11:0]};
            default: merged = s1_base;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else begin
            if (advance) begin
                out_instr <= merged;
                out_err   <= s1_err;
            end
            if (flush) begin
                out_valid <= 1'b0;
            end else if (advance) begin
                out_valid <= s1_valid;
            end
        end
    end

`ifdef IMMENC_ERRCNT_EN
    logic [CNT_W-1:0] cnt_q;

    // A handshake on a flush edge still counts; only rst clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_valid && out_ready && out_err && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign err_cnt = cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: vector table, scoreboard queue, and
// hand-written backpressure / flush / reset sequences.
module tb_imm_encoder;

    typedef struct {
        logic [2:0]  immsrc;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    localparam int NV = 16;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_immsrc;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [1:0]  err_cnt;

    vec_t vecs [NV];
    vec_t sb [$];
    vec_t cur;
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   exp_cnt   = 0;
    bit   acc;

    imm_encoder #(.CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_immsrc (in_immsrc),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] s, input logic [31:0] base,
                                input logic [31:0] imm, input logic [31:0] instr,
                                input logic err);
        vec_t v;
        v.immsrc = s;
        v.base   = base;
        v.imm    = imm;
        v.instr  = instr;
        v.err    = err;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic applyStimulus(input vec_t v);
        cur       = v;
        in_valid  = 1'b1;
        in_immsrc = v.immsrc;
        in_imm    = v.imm;
        in_base   = v.base;
    endtask

    // Called between edges: scores the coming edge, then advances to the next negedge.
    task automatic step(output bit accepted);
        vec_t e;
        bit   dlv;
        #1;
        accepted = in_valid && in_ready && !flush;
        dlv      = out_valid && out_ready && !flush;
        if (dlv) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL unexpected_out: got 0x%08h expected no output", out_instr);
            end else begin
                e = sb.pop_front();
                checkOutput("out_instr", out_instr, e.instr);
                checkOutput("out_err", {31'b0, out_err}, {31'b0, e.err});
`ifdef IMMENC_ERRCNT_EN
                if (e.err && exp_cnt != 3) exp_cnt++;
`endif
            end
        end
        if (accepted) sb.push_back(cur);
        if (flush) sb.delete();
        @(posedge clk);
        @(negedge clk);
        checkOutput("err_cnt", {30'b0, err_cnt}, exp_cnt);
    endtask

    task automatic drain();
        bit a;
        in_valid = 1'b0;
        for (int t = 0; t < 20 && sb.size() > 0; t++) step(a);
        checkOutput("drain_left", sb.size(), 0);
    endtask

    task automatic latencyCheck(input vec_t v);
        bit a;
        out_ready = 1'b1;
        applyStimulus(v);
        step(a);
        checkOutput("lat_accept", {31'b0, a}, 1);
        in_valid = 1'b0;
        checkOutput("lat_edge1_valid", {31'b0, out_valid}, 0);
        step(a);
        checkOutput("lat_edge2_valid", {31'b0, out_valid}, 1);
        step(a);
    endtask

    initial begin
        vecs[0]  = mk(3'b000, 32'h0000_0013, 32'hFFFF_F800, 32'h8000_0013, 1'b0);
        vecs[1]  = mk(3'b000, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1);
        vecs[2]  = mk(3'b001, 32'h0000_0537, 32'h1234_5000, 32'h1234_5537, 1'b0);
        vecs[3]  = mk(3'b001, 32'h0000_0537, 32'h1234_5001, 32'h1234_5537, 1'b1);
        vecs[4]  = mk(3'b011, 32'h0000_0063, 32'hFFFF_FFFE, 32'hFE00_0EE3, 1'b0);
        vecs[5]  = mk(3'b100, 32'h0000_006F, 32'hFFFF_FFFE, 32'hFFDF_F06F, 1'b0);
        vecs[6]  = mk(3'b110, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1);
        vecs[7]  = mk(3'b000, 32'h0000_0013, 32'h0000_07FF, 32'h7FF0_0013, 1'b0);
        vecs[8]  = mk(3'b010, 32'h0000_2023, 32'hFFFF_FFFC, 32'hFE00_2E23, 1'b0);
        vecs[9]  = mk(3'b010, 32'h0000_2023, 32'h0000_0800, 32'h8000_2023, 1'b1);
        vecs[10] = mk(3'b011, 32'h0000_0063, 32'h0000_0800, 32'h8000_0063, 1'b1);
        vecs[11] = mk(3'b100, 32'h0000_006F, 32'h0000_0010, 32'h0200_006F, 1'b0);
        vecs[12] = mk(3'b100, 32'h0000_006F, 32'h0008_0000, 32'h8000_006F, 1'b1);
        vecs[13] = mk(3'b101, 32'h0000_0013, 32'h0000_0000, 32'h0000_0013, 1'b1);
        vecs[14] = mk(3'b011, 32'h0000_0063, 32'h0000_0004, 32'h0000_0463, 1'b0);
        vecs[15] = mk(3'b001, 32'hFFFF_F537, 32'h1234_5000, 32'h1234_5537, 1'b0);

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_immsrc = '0;
        in_imm    = '0;
        in_base   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 0);
        checkOutput("rst_out_instr", out_instr, 0);
        checkOutput("rst_out_err", {31'b0, out_err}, 0);
        checkOutput("rst_err_cnt", {30'b0, err_cnt}, 0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 1);
        @(negedge clk);
        rst = 1'b0;

        latencyCheck(vecs[0]);

        // Flush two errored items in flight: nothing delivered, nothing counted.
        out_ready = 1'b0;
        applyStimulus(vecs[1]);
        step(acc);
        applyStimulus(vecs[3]);
        step(acc);
        checkOutput("fl_pre_valid", {31'b0, out_valid}, 1);
        in_valid = 1'b0;
        flush    = 1'b1;
        step(acc);
        flush     = 1'b0;
        out_ready = 1'b1;
        checkOutput("fl_out_valid", {31'b0, out_valid}, 0);
        repeat (3) step(acc);
        checkOutput("fl_err_cnt", {30'b0, err_cnt}, 0);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            acc = 1'b0;
            for (int t = 0; t < 8 && !acc; t++) step(acc);
            checkOutput("table_accept", {31'b0, acc}, 1);
        end
        drain();
`ifdef IMMENC_ERRCNT_EN
        checkOutput("cnt_saturated", {30'b0, err_cnt}, 3);
`else
        checkOutput("cnt_tied_zero", {30'b0, err_cnt}, 0);
`endif

        // Backpressure: two accepted, third waits, output held.
        out_ready = 1'b0;
        applyStimulus(vecs[7]);
        step(acc);
        checkOutput("bp_acc1", {31'b0, acc}, 1);
        applyStimulus(vecs[8]);
        step(acc);
        checkOutput("bp_acc2", {31'b0, acc}, 1);
        applyStimulus(vecs[11]);
        #1;
        checkOutput("bp_in_ready", {31'b0, in_ready}, 0);
        checkOutput("bp_hold_instr", out_instr, vecs[7].instr);
        step(acc);
        checkOutput("bp_acc3_blocked", {31'b0, acc}, 0);
        checkOutput("bp_hold_instr2", out_instr, vecs[7].instr);
        checkOutput("bp_hold_err", {31'b0, out_err}, {31'b0, vecs[7].err});
        out_ready = 1'b1;
        step(acc);
        checkOutput("bp_acc3", {31'b0, acc}, 1);
        in_valid = 1'b0;
        checkOutput("bp_next_valid", {31'b0, out_valid}, 1);
        step(acc);
        checkOutput("bp_last_valid", {31'b0, out_valid}, 1);
        step(acc);
        checkOutput("bp_left", sb.size(), 0);

        // Asynchronous reset in the middle of a stream.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
            step(acc);
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", {31'b0, out_valid}, 0);
        checkOutput("arst_out_instr", out_instr, 0);
        checkOutput("arst_out_err", {31'b0, out_err}, 0);
        checkOutput("arst_err_cnt", {30'b0, err_cnt}, 0);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        latencyCheck(vecs[2]);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
